hotkey_ctl: RTL and testbench
=============================

HOTKEY_CTL -- requirements
Module: hotkey_ctl

Interface
REQ-001 SHALL have parameter NMI_LEN, default 16, meaning nmi_n low-pulse length in clock cycles.
REQ-002 SHALL have parameter RST_LEN, default 1024, meaning the minimum core reset stretch in clock cycles after a reset request clears.
REQ-003 SHALL have parameter CODEC_DLY, default 1048575, meaning the clock cycles from reset until codec_rst_n releases.
REQ-004 SHALL have port clock  in  1  system clock (56 MHz); one clock, all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port kstb  in  1  one-cycle strobe; code/make valid.
REQ-007 SHALL have port make  in  1  key state: 0 = pressed (make), 1 = released (break).
REQ-008 SHALL have port code  in  8  PS/2 set-2 scan code.
REQ-009 SHALL have port ready  in  1  SDRAM initialised.
REQ-010 SHALL have port core_rst_n  out  1  active-low reset to main.
REQ-011 SHALL have port nmi_n  out  1  active-low NMI to main.
REQ-012 SHALL have port vga  out  1  video mode: 1 = VGA (scandoubled), 0 = 15 kHz RGB.
REQ-013 SHALL have port codec_rst_n  out  1  active-low audio DAC reset.

Function
REQ-014 SHALL hold six key flags (F5 03h, F12 07h, Ctrl 14h, Alt 11h, Del 71h, ScrollLock 7Eh), each 1 = released, and SHALL load make into the matching flag on kstb.
REQ-015 SHALL ignore all other codes.
REQ-016 SHALL assert reset request rq = F12 pressed OR (Ctrl AND Alt AND Del all pressed).
REQ-017 SHALL implement a reset FSM with states PWRUP, STRETCH, RUN and HOLD; core_rst_n SHALL be 1 only in RUN.
REQ-018 SHALL move PWRUP->STRETCH when ready=1, clearing the stretch counter.
REQ-019 SHALL move RUN->HOLD when rq=1.
REQ-020 SHALL move HOLD->STRETCH when rq=0, clearing the counter.
REQ-021 SHALL move STRETCH->RUN when counter = RST_LEN-1 and rq=0, and SHALL move STRETCH->HOLD if rq=1.
REQ-022 SHALL move any state->PWRUP when ready=0 (highest priority after reset).
REQ-023 SHALL size the stretch counter to $clog2(RST_LEN) bits and SHALL not wrap; it saturates at RST_LEN-1.
REQ-024 SHALL start an NMI pulse on the F5 press edge (flag 1->0 on kstb): nmi_n low for exactly NMI_LEN cycles, starting the cycle after the kstb.
REQ-025 SHALL ignore F5 auto-repeat makes (flag already 0) and presses during an active pulse.
REQ-026 SHALL suppress NMI start while core_rst_n=0 and SHALL abort an active pulse (nmi_n->1) when core_rst_n falls.
REQ-027 SHALL toggle vga on the ScrollLock press edge only; auto-repeat makes and breaks SHALL not toggle it.
REQ-028 SHALL count up from reset on a saturating codec counter and SHALL set codec_rst_n=1 at count CODEC_DLY, where it stays until the next reset; core resets and ready SHALL not affect it.
REQ-029 SHALL give reset priority when reset and kstb coincide; that kstb is dropped.
REQ-030 SHALL have no combinational path from inputs to outputs; all outputs SHALL be registered.

Reset
REQ-031 SHALL on reset=1 set: FSM=PWRUP, core_rst_n=0, nmi_n=1, vga=1, codec_rst_n=0, all key flags=1, all counters=0.
REQ-032 SHALL, when reset is asserted mid-pulse or mid-stretch, abandon the pulse or stretch with no residual effect after reset release.

Structure
REQ-033 SHALL place scan-code constants (8'h03, 8'h07, 8'h14, 8'h11, 8'h71, 8'h7E) and the FSM state enum in package hotkey_pkg.
REQ-034 SHALL use one sub-module, oneshot (parameterised length, start/abort inputs, active output), for the NMI pulse.
REQ-035 SHALL instantiate hotkey_ctl at top level in place of the inline key/reset logic, feeding main reset/nmi, the video mux select and AUDIO_RESET_n.

Verification (bench parameters: NMI_LEN=16, RST_LEN=8, CODEC_DLY=32)
REQ-036 SHALL cover: reset, ready=1 at cycle 5 -> core_rst_n rises exactly 8 cycles after PWRUP exit; codec_rst_n rises at cycle 32 after reset release.
REQ-037 SHALL cover: kstb code=14h,11h,71h make=0, then 71h make=1 -> core_rst_n low from the cycle after the third strobe, then high 8 cycles after the release.
REQ-038 SHALL cover: kstb 03h make=0, then 03h make=0 again at +5 -> nmi_n low exactly 16 cycles, a single pulse.
REQ-039 SHALL cover: F12 make at +8 within an NMI pulse -> nmi_n returns to 1 when core_rst_n falls; no NMI follows the reset.
REQ-040 SHALL cover: ScrollLock sequence make, make, break, make -> vga 1->0->1 (two toggles).
REQ-041 SHALL cover: ready dropped in RUN -> core_rst_n=0 next cycle; the full stretch repeats when ready returns.

Source files
------------

// File: rtl/hotkey_pkg.sv
// Shared constants for the hotkey controller: PS/2 set-2 scan codes of the
// watched keys, their slots in the key-flag vector, and the reset FSM states.
package hotkey_pkg;

    localparam logic [7:0] KEY_F5   = 8'h03;
    localparam logic [7:0] KEY_F12  = 8'h07;
    localparam logic [7:0] KEY_CTRL = 8'h14;
    localparam logic [7:0] KEY_ALT  = 8'h11;
    localparam logic [7:0] KEY_DEL  = 8'h71;
    localparam logic [7:0] KEY_SCRL = 8'h7E;

    localparam int NUM_FLAGS = 6;
    localparam int FLAG_F5   = 0;
    localparam int FLAG_F12  = 1;
    localparam int FLAG_CTRL = 2;
    localparam int FLAG_ALT  = 3;
    localparam int FLAG_DEL  = 4;
    localparam int FLAG_SCRL = 5;

    typedef enum logic [1:0] {
        PWRUP   = 2'd0,
        STRETCH = 2'd1,
        RUN     = 2'd2,
        HOLD    = 2'd3
    } rst_state_t;

    // One-hot flag slot for a scan code; all zero for codes we do not track.
    function automatic logic [NUM_FLAGS-1:0] key_select(input logic [7:0] code);
        logic [NUM_FLAGS-1:0] sel;
        sel = '0;
        case (code)
            KEY_F5:   sel[FLAG_F5]   = 1'b1;
            KEY_F12:  sel[FLAG_F12]  = 1'b1;
            KEY_CTRL: sel[FLAG_CTRL] = 1'b1;
            KEY_ALT:  sel[FLAG_ALT]  = 1'b1;
            KEY_DEL:  sel[FLAG_DEL]  = 1'b1;
            KEY_SCRL: sel[FLAG_SCRL] = 1'b1;
            default:  sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/hotkey_oneshot.sv
// Retriggerless one-shot: once started, 'active' stays high for exactly LEN
// cycles unless aborted. Starts arriving while active are ignored.
module oneshot #(
    parameter int LEN = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic abort,
    output logic active
);

    localparam int LW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [LW-1:0] LAST = LW'(LEN - 1);

    logic [LW-1:0] cnt;

    // Pulse timer: abort wins over everything, a running pulse ignores start.
    always_ff @(posedge clock) begin
        if (reset) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (abort) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (active) begin
            if (cnt == LAST) begin
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
        end
    end

endmodule

// File: rtl/hotkey_ctl.sv
// Keyboard hotkey controller: tracks a handful of keys from the PS/2 decoder
// and turns them into the core reset, an NMI pulse, the video-mode toggle,
// plus a one-time delayed release of the audio codec reset.
module hotkey_ctl
    import hotkey_pkg::*;
#(
    parameter int NMI_LEN   = 16,
    parameter int RST_LEN   = 1024,
    parameter int CODEC_DLY = 1048575
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       kstb,
    input  logic       make,
    input  logic [7:0] code,
    input  logic       ready,
    output logic       core_rst_n,
    output logic       nmi_n,
    output logic       vga,
    output logic       codec_rst_n
);

    localparam int CW = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
    localparam logic [CW-1:0] STRETCH_LAST = CW'(RST_LEN - 1);
    localparam int CDW = $clog2(CODEC_DLY + 1);
    localparam logic [CDW-1:0] CODEC_MAX = CDW'(CODEC_DLY);

    logic [NUM_FLAGS-1:0] key_up;
    logic [NUM_FLAGS-1:0] key_hit;
    logic                 f5_press;
    logic                 scrl_press;
    logic                 rq;
    rst_state_t           state;
    rst_state_t           state_next;
    logic [CW-1:0]        stretch_cnt;
    logic [CDW-1:0]       codec_cnt;
    logic                 nmi_active;

    assign key_hit    = kstb ? key_select(code) : '0;
    assign f5_press   = key_hit[FLAG_F5] & ~make & key_up[FLAG_F5];
    assign scrl_press = key_hit[FLAG_SCRL] & ~make & key_up[FLAG_SCRL];
    assign rq = ~key_up[FLAG_F12]
              | ~(key_up[FLAG_CTRL] | key_up[FLAG_ALT] | key_up[FLAG_DEL]);

    // Key flags follow the make/break bit of each strobe for the tracked keys.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_up <= '1;
        end else begin
            key_up <= (key_up & ~key_hit) | ({NUM_FLAGS{make}} & key_hit);
        end
    end

    // Reset sequencer state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= PWRUP;
        end else begin
            state <= state_next;
        end
    end

    // Reset sequencer transitions; losing SDRAM ready overrides everything.
    always_comb begin
        state_next = state;
        if (!ready) begin
            state_next = PWRUP;
        end else begin
            case (state)
                PWRUP:   state_next = STRETCH;
                STRETCH: begin
                    if (rq) begin
                        state_next = HOLD;
                    end else if (stretch_cnt == STRETCH_LAST) begin
                        state_next = RUN;
                    end
                end
                RUN:     if (rq) state_next = HOLD;
                HOLD:    if (!rq) state_next = STRETCH;
                default: state_next = PWRUP;
            endcase
        end
    end

    // Stretch counter restarts on every entry to STRETCH and saturates there.
    always_ff @(posedge clock) begin
        if (reset) begin
            stretch_cnt <= '0;
        end else if (state_next == STRETCH && state != STRETCH) begin
            stretch_cnt <= '0;
        end else if (state == STRETCH && stretch_cnt != STRETCH_LAST) begin
            stretch_cnt <= stretch_cnt + 1'b1;
        end
    end

    // Core reset is registered from the next state so it tracks RUN exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            core_rst_n <= 1'b0;
        end else begin
            core_rst_n <= (state_next == RUN);
        end
    end

    // NMI pulse only starts while the core runs and dies with the core reset.
    oneshot #(.LEN(NMI_LEN)) u_nmi (
        .clock  (clock),
        .reset  (reset),
        .start  (f5_press & core_rst_n),
        .abort  (state_next != RUN),
        .active (nmi_active)
    );

    assign nmi_n = ~nmi_active;

    // Video mode flips on a genuine ScrollLock press, never on auto-repeat.
    always_ff @(posedge clock) begin
        if (reset) begin
            vga <= 1'b1;
        end else if (scrl_press) begin
            vga <= ~vga;
        end
    end

    // Codec reset releases once after power-on and is untouched by core resets.
    always_ff @(posedge clock) begin
        if (reset) begin
            codec_cnt   <= '0;
            codec_rst_n <= 1'b0;
        end else begin
            if (codec_cnt != CODEC_MAX) begin
                codec_cnt <= codec_cnt + 1'b1;
            end
            if (codec_cnt == CODEC_MAX - 1'b1) begin
                codec_rst_n <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hotkey_ctl.sv
// Directed bench for hotkey_ctl: a vector table for key sequences plus
// hand-written sequences for the multi-cycle reset and NMI timing.
module tb_hotkey_ctl;

    logic       clock;
    logic       reset;
    logic       kstb;
    logic       make;
    logic [7:0] code;
    logic       ready;
    logic       core_rst_n;
    logic       nmi_n;
    logic       vga;
    logic       codec_rst_n;

    int n_checks;
    int n_fail;

    typedef struct {
        logic       kstb;
        logic [7:0] code;
        logic       make;
        logic       exp_core;
        logic       exp_nmi;
        logic       exp_vga;
        string      name;
    } vec_t;

    vec_t tbl[$];

    hotkey_ctl #(
        .NMI_LEN   (16),
        .RST_LEN   (8),
        .CODEC_DLY (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .kstb        (kstb),
        .make        (make),
        .code        (code),
        .ready       (ready),
        .core_rst_n  (core_rst_n),
        .nmi_n       (nmi_n),
        .vga         (vga),
        .codec_rst_n (codec_rst_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] c, input logic m);
        kstb = 1'b1;
        code = c;
        make = m;
        tick();
        kstb = 1'b0;
    endtask

    function automatic void add_row(input logic s, input logic [7:0] c, input logic m,
                                    input logic ec, input logic en, input logic ev,
                                    input string nm);
        vec_t v;
        v.kstb = s; v.code = c; v.make = m;
        v.exp_core = ec; v.exp_nmi = en; v.exp_vga = ev; v.name = nm;
        tbl.push_back(v);
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        kstb  = 1'b0;
        make  = 1'b1;
        code  = 8'h00;
        ready = 1'b0;

        // Ctrl-Alt-Del, then Del released; stretch runs from HOLD exit.
        add_row(1, 8'h14, 0, 1, 1, 1, "cad_ctrl");
        add_row(1, 8'h11, 0, 1, 1, 1, "cad_alt");
        add_row(1, 8'h71, 0, 1, 1, 1, "cad_del");
        add_row(0, 8'h00, 1, 0, 1, 1, "cad_hold0");
        add_row(0, 8'h00, 1, 0, 1, 1, "cad_hold1");
        add_row(1, 8'h71, 1, 0, 1, 1, "cad_del_up");
        for (int i = 0; i < 8; i++) add_row(0, 8'h00, 1, 0, 1, 1, "cad_stretch");
        add_row(0, 8'h00, 1, 1, 1, 1, "cad_run");
        add_row(1, 8'h14, 1, 1, 1, 1, "cad_ctrl_up");
        add_row(1, 8'h11, 1, 1, 1, 1, "cad_alt_up");
        // ScrollLock make, repeat make, break, make: two toggles.
        add_row(1, 8'h7E, 0, 1, 1, 0, "scrl_press1");
        add_row(1, 8'h7E, 0, 1, 1, 0, "scrl_repeat");
        add_row(1, 8'h7E, 1, 1, 1, 0, "scrl_break");
        add_row(1, 8'h7E, 0, 1, 1, 1, "scrl_press2");
        // Untracked codes change nothing.
        add_row(1, 8'h12, 0, 1, 1, 1, "other_make");
        add_row(1, 8'h1C, 0, 1, 1, 1, "other_make2");
        add_row(0, 8'h00, 1, 1, 1, 1, "other_idle");

        // Reset values.
        tick();
        tick();
        checkOutput("rst_core", core_rst_n, 1'b0);
        checkOutput("rst_nmi", nmi_n, 1'b1);
        checkOutput("rst_vga", vga, 1'b1);
        checkOutput("rst_codec", codec_rst_n, 1'b0);

        // Power-up: ready sampled at edge 5, RUN 8 edges later, codec at 32.
        reset = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            checkOutput($sformatf("pwr_core_e%0d", e), core_rst_n, (e >= 13));
            checkOutput($sformatf("pwr_codec_e%0d", e), codec_rst_n, (e >= 32));
            if (e == 4) ready = 1'b1;
        end

        // Table-driven key sequences.
        for (int i = 0; i < tbl.size(); i++) begin
            kstb = tbl[i].kstb;
            code = tbl[i].code;
            make = tbl[i].make;
            tick();
            kstb = 1'b0;
            checkOutput($sformatf("%s_%0d_core", tbl[i].name, i), core_rst_n, tbl[i].exp_core);
            checkOutput($sformatf("%s_%0d_nmi", tbl[i].name, i), nmi_n, tbl[i].exp_nmi);
            checkOutput($sformatf("%s_%0d_vga", tbl[i].name, i), vga, tbl[i].exp_vga);
        end

        // F5 press and auto-repeat at +5: one 16-cycle pulse.
        for (int j = 0; j <= 22; j++) begin
            if (j == 0 || j == 5) begin
                kstb = 1'b1; code = 8'h03; make = 1'b0;
            end else begin
                kstb = 1'b0;
            end
            tick();
            checkOutput($sformatf("nmi_pulse_j%0d", j), nmi_n, (j >= 16));
        end
        kstb = 1'b0;
        applyStimulus(8'h03, 1'b1);
        checkOutput("nmi_f5_up", nmi_n, 1'b1);

        // F12 at +8 inside a pulse: core reset aborts the pulse.
        for (int j = 0; j <= 14; j++) begin
            if (j == 0) begin
                kstb = 1'b1; code = 8'h03; make = 1'b0;
            end else if (j == 8) begin
                kstb = 1'b1; code = 8'h07; make = 1'b0;
            end else begin
                kstb = 1'b0;
            end
            tick();
            checkOutput($sformatf("abort_nmi_j%0d", j), nmi_n, (j >= 9));
            checkOutput($sformatf("abort_core_j%0d", j), core_rst_n, (j <= 8));
        end
        kstb = 1'b0;
        applyStimulus(8'h03, 1'b1);
        checkOutput("hold_f5_up", nmi_n, 1'b1);
        applyStimulus(8'h03, 1'b0);
        checkOutput("hold_f5_suppressed", nmi_n, 1'b1);
        applyStimulus(8'h07, 1'b1);
        checkOutput("f12_up_core", core_rst_n, 1'b0);
        for (int j = 1; j <= 14; j++) begin
            tick();
            checkOutput($sformatf("f12_core_j%0d", j), core_rst_n, (j >= 9));
            checkOutput($sformatf("f12_nmi_j%0d", j), nmi_n, 1'b1);
        end
        applyStimulus(8'h03, 1'b1);
        checkOutput("post_f5_up", nmi_n, 1'b1);

        // Ready lost while running: immediate core reset, full stretch after.
        ready = 1'b0;
        tick();
        checkOutput("ready_lost_core", core_rst_n, 1'b0);
        checkOutput("ready_lost_codec", codec_rst_n, 1'b1);
        ready = 1'b1;
        for (int j = 0; j <= 10; j++) begin
            tick();
            checkOutput($sformatf("ready_back_core_j%0d", j), core_rst_n, (j >= 8));
        end

        // Reset mid-pulse, coinciding with a ScrollLock strobe that must be lost.
        applyStimulus(8'h03, 1'b0);
        checkOutput("mid_nmi_start", nmi_n, 1'b0);
        tick();
        tick();
        tick();
        reset = 1'b1;
        kstb  = 1'b1; code = 8'h7E; make = 1'b0;
        tick();
        kstb  = 1'b0;
        checkOutput("mid_rst_nmi", nmi_n, 1'b1);
        checkOutput("mid_rst_core", core_rst_n, 1'b0);
        checkOutput("mid_rst_codec", codec_rst_n, 1'b0);
        checkOutput("mid_rst_vga", vga, 1'b1);
        reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            checkOutput($sformatf("after_rst_core_e%0d", e), core_rst_n, (e >= 9));
            checkOutput($sformatf("after_rst_nmi_e%0d", e), nmi_n, 1'b1);
            checkOutput($sformatf("after_rst_codec_e%0d", e), codec_rst_n, 1'b0);
        end
        applyStimulus(8'h7E, 1'b0);
        checkOutput("dropped_kstb_vga", vga, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
